// File: rtl/note_dispatcher.sv
`default_nettype none
// ============================================================================
// Module : note_dispatcher
// Walks a song ROM and hands each note to the lowest-index free note player.
// Rev    : 1.0
// ============================================================================
module note_dispatcher #(
    parameter int NUM_PLAYERS = 3,
    parameter int ENTRY_BITS  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   play,
    input  logic [1:0]             song,
    input  logic                   beat,
    output logic [ENTRY_BITS+1:0]  rom_addr,
    input  logic [15:0]            rom_data,
    input  logic [NUM_PLAYERS-1:0] player_playing,
    output logic [5:0]             note_out,
    output logic [5:0]             duration_out,
    output logic [NUM_PLAYERS-1:0] load_new_note,
    output logic                   song_done
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_WAIT_ROM   = 3'd2,
        S_DECODE     = 3'd3,
        S_DISPATCH   = 3'd4,
        S_WAIT_BEATS = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [ENTRY_BITS-1:0]  idx_q, idx_d;
    logic [15:0]            word_q, word_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [1:0]             cur_song_q, cur_song_d;
    logic [5:0]             note_q, note_d;
    logic [5:0]             dur_q, dur_d;
    logic [NUM_PLAYERS-1:0] shadow_q, shadow_d;

    logic [NUM_PLAYERS-1:0] free;
    logic [NUM_PLAYERS-1:0] pick;
    logic [NUM_PLAYERS-1:0] load;
    logic                   song_chg;
    state_t                 adv_state;
    logic [ENTRY_BITS-1:0]  adv_idx;

    // A player loaded last cycle may not have raised its busy flag yet.
    assign free      = ~player_playing & ~shadow_q;
    assign pick      = free & (~free + 1'b1);
    assign song_chg  = (song != cur_song_q);
    assign adv_state = (&idx_q) ? S_DONE : S_FETCH;
    assign adv_idx   = (&idx_q) ? idx_q : idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        cur_song_d = cur_song_q;
        note_d     = note_q;
        dur_d      = dur_q;
        load       = '0;
        if (play) begin
            if (state_q != S_IDLE && song_chg) begin
                cur_song_d = song;
                idx_d      = '0;
                cnt_d      = '0;
                state_d    = (state_q == S_DONE) ? S_IDLE : S_FETCH;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        cur_song_d = song;
                        idx_d      = '0;
                        state_d    = S_FETCH;
                    end
                    S_FETCH:    state_d = S_WAIT_ROM;
                    S_WAIT_ROM: begin
                        word_d  = rom_data;
                        state_d = S_DECODE;
                    end
                    S_DECODE: begin
                        if (word_q == 16'h0000) begin
                            state_d = S_DONE;
                        end else if (!word_q[15]) begin
                            state_d = S_DISPATCH;
                        end else if (word_q[8:3] == 6'd0) begin
                            state_d = adv_state;
                            idx_d   = adv_idx;
                        end else begin
                            cnt_d   = word_q[8:3];
                            state_d = S_WAIT_BEATS;
                        end
                    end
                    S_DISPATCH: begin
                        if (|free) begin
                            load    = pick;
                            note_d  = word_q[14:9];
                            dur_d   = word_q[8:3];
                            state_d = adv_state;
                            idx_d   = adv_idx;
                        end
                    end
                    S_WAIT_BEATS: begin
                        if (beat) begin
                            if (cnt_q == 6'd1) begin
                                cnt_d   = '0;
                                state_d = adv_state;
                                idx_d   = adv_idx;
                            end else begin
                                cnt_d = cnt_q - 6'd1;
                            end
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
        shadow_d = load;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            cur_song_q <= '0;
            note_q     <= '0;
            dur_q      <= '0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            cur_song_q <= cur_song_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            shadow_q   <= shadow_d;
        end
    end

    assign rom_addr      = {song, idx_q};
    assign load_new_note = load;
    assign note_out      = (|load) ? word_q[14:9] : note_q;
    assign duration_out  = (|load) ? word_q[8:3] : dur_q;
    assign song_done     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: doc/note_dispatcher.md
NOTE_DISPATCHER -- requirements
Module: note_dispatcher

Interface
REQ-001 Parameter NUM_PLAYERS, 3, number of note players driven; load and playing vectors are NUM_PLAYERS bits wide.
REQ-002 Parameter ENTRY_BITS, 5, entries per song = 2^ENTRY_BITS.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 play  input  1  high = advance song; low = pause, hold all state.
REQ-006 song  input  2  song select; forms upper rom_addr bits.
REQ-007 beat  input  1  single-cycle 1/48 s tick.
REQ-008 rom_addr  output  2+ENTRY_BITS  {song, entry index} to song ROM.
REQ-009 rom_data  input  16  ROM word, valid exactly 1 cycle after rom_addr is presented (synchronous ROM).
REQ-010 player_playing  input  NUM_PLAYERS  per-player busy flag from note players.
REQ-011 note_out  output  6  note code to load.
REQ-012 duration_out  output  6  duration in beats to load.
REQ-013 load_new_note  output  NUM_PLAYERS  one-hot single-cycle load strobe.
REQ-014 song_done  output  1  high while in DONE.

Function
REQ-015 ROM word: bit15 = advance flag; bits14:9 = note; bits8:3 = duration; bits2:0 ignored.
REQ-016 Word 16'h0000 is end-of-song.
REQ-017 States: IDLE, FETCH, WAIT_ROM, DECODE, DISPATCH, WAIT_BEATS, DONE.
REQ-018 IDLE -> FETCH on play=1; rom_addr = {song, entry}, entry starts at 0.
REQ-019 FETCH -> WAIT_ROM unconditionally; WAIT_ROM -> DECODE, capturing rom_data into an entry register.
REQ-020 DECODE: end-of-song -> DONE; advance=1 with duration 0 -> FETCH with entry+1; advance=1 with duration>0 -> WAIT_BEATS with beat counter = duration; advance=0 -> DISPATCH.
REQ-021 DISPATCH: a player is free if player_playing[i]=0 and it was not loaded in the previous cycle (1-cycle shadow mask, covering the player's one-cycle playing-flag update lag).
REQ-022 DISPATCH: the lowest-index free player gets load_new_note[i]=1 for exactly one cycle, with note_out/duration_out = captured fields in that same cycle; next state FETCH with entry+1.
REQ-023 DISPATCH: with no free player, stall in DISPATCH with no load and no entry change until one frees; notes are never dropped.
REQ-024 WAIT_BEATS: counter decrements by 1 on each beat; when a beat arrives with counter=1 -> FETCH with entry+1; beats in any other state are ignored.
REQ-025 Entry increment from 2^ENTRY_BITS-1 enters DONE instead of wrapping.
REQ-026 DONE holds with song_done=1; exits to IDLE only on a change of song.
REQ-027 A change of song in any state except IDLE resets entry to 0 and goes to FETCH next cycle (DONE -> IDLE), with no load issued that cycle.
REQ-028 play=0 in any state freezes state, entry, and beat counter; load_new_note forced to 0; beats lost while paused are not replayed.
REQ-029 load_new_note is 0 in every state except DISPATCH; at most one bit is high per cycle.
REQ-030 note_out/duration_out hold their last values when not loading.

Reset
REQ-031 On reset: state=IDLE, entry=0, beat counter=0, shadow mask=0, load_new_note=0, note_out=0, duration_out=0, song_done=0, rom_addr={song,0}.
REQ-032 Reset asserted mid-song aborts immediately; no load strobe is issued in the cycle reset deasserts.

Verification
REQ-033 Song 0 = {note 12 dur 8, advance 4, 0x0000}, all players free, play=1 -> load_new_note=001 with note 12 dur 8, then 4 beats, then song_done=1.
REQ-034 Three back-to-back notes, playing=000 and then following the loads with 1-cycle lag -> loads on 001, 010, 100 in turn; no player loaded twice.
REQ-035 Fourth note with playing=111 -> stall with no load; drop playing[1] -> load_new_note=010 the next DISPATCH cycle.
REQ-036 advance 3 with play dropped after first beat for 10 beats, then restored -> exactly 2 more beats needed before next FETCH.
REQ-037 32 non-terminating entries -> DONE after entry 31; change song 0->1 -> IDLE, then rom_addr={1,0}.
REQ-038 Reset pulse during WAIT_BEATS -> all outputs at reset values asynchronously; state IDLE.
